reg_scoreboard: RTL

- Producer-side companion to the EX→ID operand forwarding path in the RV32 core.
- Tracks destination registers of issued long-latency ops (loads, mul/div) whose result does not exist in EX, so forwarding cannot supply it.
- Stalls ID on RAW/WAW hazards against those registers and releases them when the writeback port retires the write.
- Sits beside ID; its stall output gates ID→EX issue.

---
 rtl/reg_scoreboard.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Tracks destination registers of long-latency instructions (loads, mul/div)
// that have left ID but whose results only appear at writeback, so the EX->ID
// forwarding network cannot supply them. ID is stalled on RAW/WAW hazards
// against those registers, and also when the pending table is full. An entry
// is released when the long-latency writeback port retires the write.
//
// Ports:
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   ID_rs1/_vld     source register 1 of the ID instruction and its valid
//   ID_rs2/_vld     source register 2 of the ID instruction and its valid
//   ID_rd/_vld      destination register of the ID instruction and its valid
//   ID_long         ID instruction is long-latency (result only at WB)
//   ID_issue        ID instruction moves to EX this cycle
//   WB_rd/_vld      register retired by a long-latency writeback
//   SB_stall        combinational: hold ID and insert a bubble
//   SB_pending      registered bitmap, bit n set while xn is outstanding
//   SB_cnt          registered number of set bits in SB_pending
//   SB_busy         SB_cnt != 0
//   SB_err          sticky: a writeback retired a register that was not pending
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic             ID_rs1_vld,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_rs2_vld,
    input  logic [4:0]       ID_rd,
    input  logic             ID_rd_vld,
    input  logic             ID_long,
    input  logic             ID_issue,
    input  logic [4:0]       WB_rd,
    input  logic             WB_rd_vld,
    output logic             SB_stall,
    output logic [31:0]      SB_pending,
    output logic [CNT_W-1:0] SB_cnt,
    output logic             SB_busy,
    output logic             SB_err
);

    logic [31:0]      pending_reg;
    logic [31:0]      pending_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             err_reg;
    logic             err_next;

    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             full;
    logic             set;
    logic             clr;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;

    // Hazard terms look only at registered state. A writeback in this cycle
    // deliberately does not release the stall until the next cycle so the
    // register file has a cycle to commit the value.
    assign raw1 = ID_rs1_vld && (ID_rs1 != 5'd0) && pending_reg[ID_rs1];
    assign raw2 = ID_rs2_vld && (ID_rs2 != 5'd0) && pending_reg[ID_rs2];
    assign waw  = ID_rd_vld  && (ID_rd  != 5'd0) && pending_reg[ID_rd];
    assign full = ID_long && ID_rd_vld && (ID_rd != 5'd0)
               && (cnt_reg == CNT_W'(MAX_PENDING));

    assign SB_stall = raw1 || raw2 || waw || full;

    // An issue attempted while stalled is ignored, so the table can never
    // overflow and a pending register can never be set twice.
    assign set = ID_issue && !SB_stall && ID_long && ID_rd_vld && (ID_rd != 5'd0);
    assign clr = WB_rd_vld && (WB_rd != 5'd0) && pending_reg[WB_rd];

    // One-hot decode of the set/clear targets. Bit 0 stays constant zero so
    // x0 is never tracked.
    assign set_mask[0] = 1'b0;
    assign clr_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_decode
            assign set_mask[gi] = set && (ID_rd == 5'(gi));
            assign clr_mask[gi] = clr && (WB_rd == 5'(gi));
        end
    endgenerate

    // set and clr can never hit the same register (waw blocks that), so the
    // order of OR and AND-NOT below does not matter.
    assign pending_next = (pending_reg | set_mask) & ~clr_mask;

    always_comb begin
        cnt_next = cnt_reg;
        case ({set, clr})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    // Any writeback that did not release a pending entry (x0 or not pending)
    // is flagged and latched until reset.
    assign err_next = err_reg || (WB_rd_vld && !clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
        end
    end

    assign SB_pending = pending_reg;
    assign SB_cnt     = cnt_reg;
    assign SB_busy    = (cnt_reg != '0);
    assign SB_err     = err_reg;

endmodule
